// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver_if
// Brief   : Value/control inputs and digit/segment outputs of the 7-seg scanner.
// Revision: 1.0 - initial release
// ============================================================================
interface seg7_scan_driver_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_lz;
  logic [BRIGHT_W-1:0] brightness;
  logic [DIGITS-1:0]   display_sel;
  logic [7:0]          display;
  logic                frame_start;

  modport master (
    output value, dp, load, blank_lz, brightness,
    input  display_sel, display, frame_start
  );

  modport slave (
    input  value, dp, load, blank_lz, brightness,
    output display_sel, display, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Multiplexed 7-seg scan driver with frame-synchronous double buffer,
//           leading-zero blanking and PWM brightness.
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_LOG2   = 16,
  parameter int BRIGHT_W       = 4,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  seg7_scan_driver_if.slave bus
);

  localparam int               IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] c_SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        c_SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [REFRESH_LOG2-1:0] r_prescaler;
  logic [IDX_W-1:0]        r_index;
  logic [4*DIGITS-1:0]     r_pending_val;
  logic [DIGITS-1:0]       r_pending_dp;
  logic                    r_pending_valid;
  logic [4*DIGITS-1:0]     r_active_val;
  logic [DIGITS-1:0]       r_active_dp;
  logic [DIGITS-1:0]       r_display_sel;
  logic [7:0]              r_display;
  logic                    r_frame_start;

  logic                    w_presc_wrap;
  logic                    w_last;
  logic                    w_frame;
  logic                    w_slot0;
  logic [BRIGHT_W-1:0]     w_phase;
  logic                    w_enable;
  logic [DIGITS-1:0]       w_zero_above;
  logic [3:0]              w_nibble;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic [DIGITS-1:0]       w_onehot;
  logic [6:0]              w_glyph;
  logic [7:0]              w_seg_raw;
  logic [DIGITS-1:0]       w_sel_next;
  logic [7:0]              w_seg_next;

  assign w_presc_wrap = &r_prescaler;
  assign w_last       = (r_index == IDX_W'(DIGITS - 1));
  assign w_frame      = w_presc_wrap & w_last;
  assign w_slot0      = (r_index == '0) && (r_prescaler == '0);

  assign w_phase  = r_prescaler[REFRESH_LOG2-1 -: BRIGHT_W];
  assign w_enable = (&bus.brightness) || (w_phase < bus.brightness);

  // w_zero_above[i] is set when nibbles DIGITS-1 down to i are all zero.
  always_comb begin : zero_scan
    logic v_run;
    v_run        = 1'b1;
    w_zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_run           = v_run && (r_active_val[4*i +: 4] == 4'h0);
      w_zero_above[i] = v_run;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_nibble    = r_active_val[4*i +: 4];
        w_dp_bit    = r_active_dp[i];
        w_blank     = bus.blank_lz && (i != 0) && w_zero_above[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = 7'h00;
    endcase
  end

  // A disabled PWM phase forces segments off too, so nothing ghosts onto the next digit.
  always_comb begin
    w_seg_raw  = {w_dp_bit, (w_blank ? 7'h00 : w_glyph)};
    w_sel_next = c_SEL_OFF;
    w_seg_next = c_SEG_OFF;
    if (w_enable) begin
      w_sel_next = (SEL_ACTIVE_LOW != 0) ? ~w_onehot  : w_onehot;
      w_seg_next = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prescaler     <= '0;
      r_index         <= '0;
      r_pending_val   <= '0;
      r_pending_dp    <= '0;
      r_pending_valid <= 1'b0;
      r_active_val    <= '0;
      r_active_dp     <= '0;
      r_display_sel   <= c_SEL_OFF;
      r_display       <= c_SEG_OFF;
      r_frame_start   <= 1'b0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
      if (w_presc_wrap) begin
        r_index <= w_last ? '0 : r_index + 1'b1;
      end

      // A load coinciding with the frame boundary bypasses the pending buffer.
      if (bus.load) begin
        if (w_frame) begin
          r_active_val    <= bus.value;
          r_active_dp     <= bus.dp;
          r_pending_valid <= 1'b0;
        end else begin
          r_pending_val   <= bus.value;
          r_pending_dp    <= bus.dp;
          r_pending_valid <= 1'b1;
        end
      end else if (w_frame && r_pending_valid) begin
        r_active_val    <= r_pending_val;
        r_active_dp     <= r_pending_dp;
        r_pending_valid <= 1'b0;
      end

      r_display_sel <= w_sel_next;
      r_display     <= w_seg_next;
      r_frame_start <= w_slot0;
    end
  end

  assign bus.display_sel = r_display_sel;
  assign bus.display     = r_display;
  assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Directed self-checking bench for seg7_scan_driver (4 digits, 16-cycle slots).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int REFRESH_LOG2 = 4;
  localparam int BRIGHT_W     = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg7_scan_driver_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  seg7_scan_driver #(
    .DIGITS        (DIGITS),
    .REFRESH_LOG2  (REFRESH_LOG2),
    .BRIGHT_W      (BRIGHT_W),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Returns on the negedge where frame_start is seen high (output slot 0, cycle 0).
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    logic [3:0] exp_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset_n        = 1'b0;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.dp         = '0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1111) begin n_fail++; $display("FAIL reset_sel: got %b expected 1111", bus.display_sel); end
    n_checks++;
    if (bus.display !== 8'hFF) begin n_fail++; $display("FAIL reset_display: got %h expected ff", bus.display); end
    n_checks++;
    if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", bus.frame_start); end
    reset_n = 1'b1;
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_first_frame: got timeout expected frame_start"); end
    n_checks++;
    if (bus.display !== 8'hC0) begin n_fail++; $display("FAIL reset_digit0_zero: got %h expected c0", bus.display); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display_sel !== exp_sel[k]) begin n_fail++; $display("FAIL scan_sel_start slot%0d: got %b expected %b", k, bus.display_sel, exp_sel[k]); end
      repeat (15) @(negedge clk);
      n_checks++;
      if (bus.display_sel !== exp_sel[k]) begin n_fail++; $display("FAIL scan_sel_end slot%0d: got %b expected %b", k, bus.display_sel, exp_sel[k]); end
      if (k == 0) begin
        n_checks++;
        if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL frame_start_width: got %b expected 0", bus.frame_start); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL frame_period: got %b expected 1 after 64 cycles", bus.frame_start); end
  endtask

  task automatic test_load_mid_frame();
    bit ok;
    logic [7:0] exp_seg [4] = '{8'h8E, 8'h08, 8'hA4, 8'hF9};
    logic [3:0] exp_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_sync: got timeout expected frame_start"); end
    repeat (20) @(negedge clk);
    bus.value = 16'h12AF;
    bus.dp    = 4'b0010;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    repeat (11) @(negedge clk);
    n_checks++;
    if (bus.display !== 8'hC0) begin n_fail++; $display("FAIL load_old_slot2: got %h expected c0", bus.display); end
    repeat (16) @(negedge clk);
    n_checks++;
    if (bus.display !== 8'hC0) begin n_fail++; $display("FAIL load_old_slot3: got %h expected c0", bus.display); end
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_new_frame: got timeout expected frame_start"); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display !== exp_seg[k] || bus.display_sel !== exp_sel[k]) begin
        n_fail++;
        $display("FAIL load_new slot%0d: got %h/%b expected %h/%b", k, bus.display, bus.display_sel, exp_seg[k], exp_sel[k]);
      end
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [7:0] exp_a [4] = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
    logic [7:0] exp_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    bus.blank_lz = 1'b1;
    bus.value    = 16'h0030;
    bus.dp       = 4'b0000;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL blank_sync: got timeout expected frame_start"); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display !== exp_a[k]) begin n_fail++; $display("FAIL blank_0030 slot%0d: got %h expected %h", k, bus.display, exp_a[k]); end
      repeat (16) @(negedge clk);
    end
    bus.value = 16'h0000;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    wait_frame(ok);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display !== exp_b[k]) begin n_fail++; $display("FAIL blank_0000 slot%0d: got %h expected %h", k, bus.display, exp_b[k]); end
      repeat (16) @(negedge clk);
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    bit ok;
    int n_bad;
    bus.brightness = 2'd1;
    wait_frame(ok);
    n_checks++;
    if (bus.display_sel !== 4'b1110 || bus.display !== 8'hC0) begin n_fail++; $display("FAIL pwm_cycle0: got %b/%h expected 1110/c0", bus.display_sel, bus.display); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1110) begin n_fail++; $display("FAIL pwm_cycle3: got %b expected 1110", bus.display_sel); end
    @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1111 || bus.display !== 8'hFF) begin n_fail++; $display("FAIL pwm_cycle4: got %b/%h expected 1111/ff", bus.display_sel, bus.display); end
    repeat (11) @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1111) begin n_fail++; $display("FAIL pwm_cycle15: got %b expected 1111", bus.display_sel); end
    @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1101) begin n_fail++; $display("FAIL pwm_slot1_on: got %b expected 1101", bus.display_sel); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.display_sel !== 4'b1111) begin n_fail++; $display("FAIL pwm_slot1_off: got %b expected 1111", bus.display_sel); end
    bus.brightness = 2'd0;
    n_bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i > 0 && (bus.display_sel !== 4'b1111 || bus.display !== 8'hFF)) n_bad++;
    end
    n_checks++;
    if (n_bad !== 0) begin n_fail++; $display("FAIL pwm_dark: got %0d lit cycles expected 0", n_bad); end
    bus.brightness = 2'd3;
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_sync: got timeout expected frame_start"); end
    repeat (62) @(negedge clk);
    bus.value = 16'h5555;
    bus.dp    = 4'b0000;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.value = 16'h6666;
    @(negedge clk);
    bus.load  = 1'b0;
    n_checks++;
    if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_align: got %b expected 1", bus.frame_start); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display !== 8'h92) begin n_fail++; $display("FAIL b2b_boundary_load slot%0d: got %h expected 92", k, bus.display); end
      repeat (16) @(negedge clk);
    end
    // Already sitting on the next pulse; its contents must be the deferred load.
    n_checks++;
    if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL b2b_second_frame: got %b expected 1", bus.frame_start); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.display !== 8'h82) begin n_fail++; $display("FAIL b2b_deferred slot%0d: got %h expected 82", k, bus.display); end
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_frame(ok);
    repeat (37) @(negedge clk);
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.display_sel !== 4'b1111 || bus.display !== 8'hFF) begin n_fail++; $display("FAIL async_reset: got %b/%h expected 1111/ff", bus.display_sel, bus.display); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_frame(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_restart: got timeout expected frame_start"); end
    n_checks++;
    if (bus.display_sel !== 4'b1110 || bus.display !== 8'hC0) begin n_fail++; $display("FAIL reset_restart_slot0: got %b/%h expected 1110/c0", bus.display_sel, bus.display); end
    wait_frame(ok);
    n_checks++;
    if (bus.display !== 8'hC0) begin n_fail++; $display("FAIL reset_pending_cleared: got %h expected c0", bus.display); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_mid_frame();
    test_blanking();
    test_pwm();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
